// File: rtl/one_to_two_demux_pkg.sv
// ----------------------------------------------------------------------------
// one_to_two_demux_pkg
// Purpose : Shared defaults, channel-index constants and the slot state type
//           used by the 1:2 demux and its holding slots.
// Contents: DEF_WIDTH, DEF_CNT_W - default data / counter widths
//           CH0, CH1             - values of in_sel that select each channel
//           slot_state_e         - EMPTY/FULL state of a one-entry slot
// ----------------------------------------------------------------------------
package one_to_two_demux_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    typedef enum logic [0:0] {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/one_to_two_demux_if.sv
// ----------------------------------------------------------------------------
// one_to_two_demux_if
// Purpose : Bundles the input handshake, both output channels and the
//           per-channel delivery counters of the 1:2 demux.
// Signals : in_valid/in_ready/in_sel/in_data       - source side
//           outX_valid/outX_ready/outX_data         - sink side, X = 0, 1
//           cnt0/cnt1                               - words delivered per channel
// Modports: slave  - the demux itself
//           master - the environment (source + both sinks)
// ----------------------------------------------------------------------------
interface one_to_two_demux_if
    import one_to_two_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  in_valid, in_sel, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

    modport master (
        output in_valid, in_sel, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

endinterface

// File: rtl/one_to_two_demux_slot.sv
// ----------------------------------------------------------------------------
// demux_slot
// Purpose : One-entry holding buffer for one demux channel: EMPTY/FULL state,
//           registered data word and a wrapping count of words delivered.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_wr          - load i_wr_data this cycle (caller guarantees o_ready)
//           i_wr_data     - word to load
//           i_rd_ready    - sink takes the held word
//           o_ready       - slot can take a word this cycle
//           o_valid       - slot holds a word
//           o_data        - held word
//           o_cnt         - words delivered, wraps at 2^CNT_W
// ----------------------------------------------------------------------------
module demux_slot
    import one_to_two_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_ready,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_cnt
);

    slot_state_e      r_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_cnt;
    logic             w_drain;

    assign w_drain = (r_state == SlotFull) && i_rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SlotEmpty;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                SlotEmpty: begin
                    if (i_wr) begin
                        r_state <= SlotFull;
                        r_data  <= i_wr_data;
                    end
                end
                SlotFull: begin
                    // A write in the drain cycle refills without a bubble.
                    if (i_wr) begin
                        r_data <= i_wr_data;
                    end else if (i_rd_ready) begin
                        r_state <= SlotEmpty;
                    end
                end
                default: r_state <= SlotEmpty;
            endcase
            if (w_drain) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // A full slot can still accept when its word leaves in the same cycle.
    assign o_ready = (r_state == SlotEmpty) || i_rd_ready;
    assign o_valid = (r_state == SlotFull);
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/one_to_two_demux.sv
// ----------------------------------------------------------------------------
// one_to_two_demux
// Purpose : Routes each accepted input word to one of two output channels,
//           each backed by a one-entry slot, so a stalled channel never blocks
//           the other.
// Ports   : clk  - sole clock, rising edge
//           rst  - synchronous active-high reset
//           bus  - one_to_two_demux_if.slave: input handshake, two output
//                  channels and per-channel delivery counters
// ----------------------------------------------------------------------------
module one_to_two_demux
    import one_to_two_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    one_to_two_demux_if.slave bus
);

    logic w_rdy0;
    logic w_rdy1;
    logic w_in_ready;
    logic w_accept;
    logic w_wr0;
    logic w_wr1;

    // Readiness depends only on the addressed slot; the other channel is ignored.
    assign w_in_ready = !rst && ((bus.in_sel == CH1) ? w_rdy1 : w_rdy0);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_wr0      = w_accept && (bus.in_sel == CH0);
    assign w_wr1      = w_accept && (bus.in_sel == CH1);

    assign bus.in_ready = w_in_ready;

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (w_wr0),
        .i_wr_data  (bus.in_data),
        .i_rd_ready (bus.out0_ready),
        .o_ready    (w_rdy0),
        .o_valid    (bus.out0_valid),
        .o_data     (bus.out0_data),
        .o_cnt      (bus.cnt0)
    );

    demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (w_wr1),
        .i_wr_data  (bus.in_data),
        .i_rd_ready (bus.out1_ready),
        .o_ready    (w_rdy1),
        .o_valid    (bus.out1_valid),
        .o_data     (bus.out1_data),
        .o_cnt      (bus.cnt1)
    );

endmodule

// File: tb/tb_one_to_two_demux.sv
// ----------------------------------------------------------------------------
// tb_one_to_two_demux
// Purpose : Self-checking bench for one_to_two_demux. A queue-per-channel
//           reference model tracks words waiting on each output and counts
//           deliveries; every scenario compares the DUT against it.
// ----------------------------------------------------------------------------
module tb_one_to_two_demux;

    logic clk;
    logic rst;

    one_to_two_demux_if #(.WIDTH(8), .CNT_W(8)) bus ();

    one_to_two_demux #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words waiting per channel and deliveries per channel.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         c0 = 0;
    int         c1 = 0;

    logic exp_rdy;
    logic act_rdy;

    function automatic logic model_rdy(input logic sel, input logic r0, input logic r1);
        if (sel) return (q1.size() == 0) || r1;
        return (q0.size() == 0) || r0;
    endfunction

    // One clock cycle: drive inputs, sample in_ready, clock, advance the model.
    // Returns just after the following falling edge.
    task automatic tick(input logic v, input logic sel, input logic [7:0] d,
                        input logic r0, input logic r1);
        bus.in_valid   = v;
        bus.in_sel     = sel;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        #1;
        exp_rdy = !rst && model_rdy(sel, r0, r1);
        act_rdy = bus.in_ready;
        @(posedge clk);
        if (rst) begin
            q0.delete();
            q1.delete();
            c0 = 0;
            c1 = 0;
        end else begin
            if (q0.size() != 0 && r0) begin
                void'(q0.pop_front());
                c0++;
            end
            if (q1.size() != 0 && r1) begin
                void'(q1.pop_front());
                c1++;
            end
            if (v && exp_rdy) begin
                if (sel) q1.push_back(d);
                else     q0.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
            n_vec++;
            if (act_rdy !== 1'b0) begin
                $display("FAIL rst_in_ready: got %b want 0", act_rdy);
                n_err++;
            end
        end
        rst = 1'b0;
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
            $display("FAIL rst_valid: got %b%b want 00", bus.out0_valid, bus.out1_valid);
            n_err++;
        end
        n_vec++;
        if (bus.cnt0 !== 8'd0 || bus.cnt1 !== 8'd0) begin
            $display("FAIL rst_cnt: got %0d/%0d want 0/0", bus.cnt0, bus.cnt1);
            n_err++;
        end
        n_vec++;
        if (bus.out0_data !== 8'h00 || bus.out1_data !== 8'h00) begin
            $display("FAIL rst_data: got %h/%h want 00/00", bus.out0_data, bus.out1_data);
            n_err++;
        end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL idle_in_ready: got %b want 1", bus.in_ready);
            n_err++;
        end
    endtask

    task automatic test_basic();
        tick(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
        n_vec++;
        if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'hA5) begin
            $display("FAIL basic_out0: got v=%b d=%h want v=1 d=a5",
                     bus.out0_valid, bus.out0_data);
            n_err++;
        end
        tick(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        n_vec++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'h3C) begin
            $display("FAIL basic_out1: got v=%b d=%h want v=1 d=3c",
                     bus.out1_valid, bus.out1_data);
            n_err++;
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_vec++;
        if (bus.cnt0 !== 8'(c0) || bus.cnt1 !== 8'(c1) || bus.cnt0 !== 8'd1 || bus.cnt1 !== 8'd1)
        begin
            $display("FAIL basic_cnt: got %0d/%0d want 1/1", bus.cnt0, bus.cnt1);
            n_err++;
        end
    endtask

    task automatic test_stall();
        tick(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
        n_vec++;
        if (act_rdy !== 1'b0 || act_rdy !== exp_rdy) begin
            $display("FAIL stall_in_ready: got %b want 0", act_rdy);
            n_err++;
        end
        n_vec++;
        if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'h11) begin
            $display("FAIL stall_hold: got v=%b d=%h want v=1 d=11",
                     bus.out0_valid, bus.out0_data);
            n_err++;
        end
        tick(1'b1, 1'b1, 8'h33, 1'b0, 1'b1);
        n_vec++;
        if (act_rdy !== 1'b1 || bus.out1_valid !== 1'b1 || bus.out1_data !== 8'h33) begin
            $display("FAIL stall_other: got rdy=%b v=%b d=%h want rdy=1 v=1 d=33",
                     act_rdy, bus.out1_valid, bus.out1_data);
            n_err++;
        end
        n_vec++;
        if (bus.out0_data !== 8'h11) begin
            $display("FAIL stall_hold2: got %h want 11", bus.out0_data);
            n_err++;
        end
        // Drain and refill in one cycle: slot stays full with the new word.
        tick(1'b1, 1'b0, 8'h22, 1'b1, 1'b1);
        n_vec++;
        if (act_rdy !== 1'b1 || bus.out0_valid !== 1'b1 || bus.out0_data !== q0[0]
            || bus.out0_data !== 8'h22) begin
            $display("FAIL refill: got rdy=%b v=%b d=%h want rdy=1 v=1 d=22",
                     act_rdy, bus.out0_valid, bus.out0_data);
            n_err++;
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_vec++;
        if (bus.out0_valid !== 1'b0 || bus.cnt0 !== 8'(c0)) begin
            $display("FAIL stall_drain: got v=%b cnt=%0d want v=0 cnt=%0d",
                     bus.out0_valid, bus.cnt0, c0);
            n_err++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            tick(1'b1, 1'b1, d, 1'b1, 1'b1);
            n_vec++;
            if (act_rdy !== 1'b1 || bus.out1_valid !== 1'b1 || bus.out1_data !== d) begin
                $display("FAIL stream[%0d]: got rdy=%b v=%b d=%h want rdy=1 v=1 d=%h",
                         i, act_rdy, bus.out1_valid, bus.out1_data, d);
                n_err++;
            end
        end
        tick(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
        n_vec++;
        if (bus.cnt1 !== 8'd10 || bus.cnt1 !== 8'(c1)) begin
            $display("FAIL stream_cnt: got %0d want 10", bus.cnt1);
            n_err++;
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            tick(1'b1, 1'b0, 8'(i), 1'b1, 1'b1);
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        n_vec++;
        if (bus.cnt0 !== 8'd1 || bus.cnt0 !== 8'(c0)) begin
            $display("FAIL wrap_cnt0: got %0d want 1", bus.cnt0);
            n_err++;
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
        n_vec++;
        if (bus.out0_valid !== 1'b1 || bus.out1_valid !== 1'b1) begin
            $display("FAIL mid_fill: got %b%b want 11", bus.out0_valid, bus.out1_valid);
            n_err++;
        end
        rst = 1'b1;
        tick(1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);
        rst = 1'b0;
        n_vec++;
        if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0 || bus.cnt0 !== 8'd0
            || bus.cnt1 !== 8'd0) begin
            $display("FAIL mid_rst: got v=%b%b cnt=%0d/%0d want v=00 cnt=0/0",
                     bus.out0_valid, bus.out1_valid, bus.cnt0, bus.cnt1);
            n_err++;
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (bus.out0_valid !== 1'b0) begin
            $display("FAIL mid_lost: got v=%b want 0", bus.out0_valid);
            n_err++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom), 1'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            n_vec++;
            if (act_rdy !== exp_rdy) begin
                $display("FAIL rnd_rdy[%0d]: got %b want %b", i, act_rdy, exp_rdy);
                n_err++;
            end
            n_vec++;
            if (bus.out0_valid !== (q0.size() != 0) || bus.out1_valid !== (q1.size() != 0))
            begin
                $display("FAIL rnd_valid[%0d]: got %b%b want %b%b", i, bus.out0_valid,
                         bus.out1_valid, q0.size() != 0, q1.size() != 0);
                n_err++;
            end
            if (q0.size() != 0) begin
                n_vec++;
                if (bus.out0_data !== q0[0]) begin
                    $display("FAIL rnd_d0[%0d]: got %h want %h", i, bus.out0_data, q0[0]);
                    n_err++;
                end
            end
            if (q1.size() != 0) begin
                n_vec++;
                if (bus.out1_data !== q1[0]) begin
                    $display("FAIL rnd_d1[%0d]: got %h want %h", i, bus.out1_data, q1[0]);
                    n_err++;
                end
            end
            n_vec++;
            if (bus.cnt0 !== 8'(c0) || bus.cnt1 !== 8'(c1)) begin
                $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, bus.cnt0,
                         bus.cnt1, 8'(c0), 8'(c1));
                n_err++;
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = 8'h00;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/one_to_two_demux.md
ONE_TO_TWO_DEMUX -- requirements
Module: one_to_two_demux

Interface
REQ-001 Parameter WIDTH, default 8, data width of every data port.
REQ-002 Parameter CNT_W, default 8, width of each per-channel transfer counter.
REQ-003 Clock: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Reset: rst, input, 1, synchronous, active-high.
REQ-005 in_valid input 1: source offers a word this cycle.
REQ-006 in_ready output 1: block accepts the offered word this cycle.
REQ-007 in_sel input 1: destination channel (0 -> out0, 1 -> out1), sampled with in_data.
REQ-008 in_data input WIDTH: word to route.
REQ-009 out0_valid / out1_valid output 1: channel holds a word.
REQ-010 out0_ready / out1_ready input 1: sink takes the held word.
REQ-011 out0_data / out1_data output WIDTH: held word, registered.
REQ-012 cnt0 / cnt1 output CNT_W: words delivered per channel.

Function
REQ-013 Each channel SHALL own one one-entry holding slot (full flag + data register).
REQ-014 Input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-015 in_ready SHALL equal (!full[in_sel]) or (full[in_sel] and out<in_sel>_ready), combinationally from in_sel and slot state.
REQ-016 A transfer SHALL write in_data into the slot selected by in_sel and set its full flag; the other slot SHALL be unchanged.
REQ-017 Latency SHALL be one cycle: a word accepted at edge N appears on outX_data with outX_valid=1 after edge N.
REQ-018 outX_valid SHALL equal the channel's full flag; outX_data SHALL hold its value while outX_valid=1 and outX_ready=0.
REQ-019 Output transfer SHALL occur when outX_valid and outX_ready are both 1; the slot SHALL clear unless refilled in the same cycle.
REQ-020 Simultaneous drain and refill of the same slot SHALL keep full=1 and load the new word (no bubble, full throughput per channel).
REQ-021 Each slot SHALL be a two-state machine, EMPTY and FULL: EMPTY->FULL on write; FULL->EMPTY on drain without write; FULL->FULL on write with drain or on no drain.
REQ-022 A stalled channel SHALL NOT block the other: with in_sel selecting a non-full or draining slot, in_ready=1 regardless of the other channel.
REQ-023 cntX SHALL increment by 1 on each output transfer on channel X and wrap from 2^CNT_W-1 to 0.
REQ-024 in_valid=1 with in_ready=0 SHALL leave all state unchanged; the source must hold in_data and in_sel.
REQ-025 outX_valid SHALL NOT depend combinationally on outX_ready or any input-side signal.

Reset
REQ-026 While rst=1 at a rising edge: both full flags 0, out0_valid=out1_valid=0, cnt0=cnt1=0, out0_data=out1_data=0.
REQ-027 Reset mid-operation SHALL discard held words; a transfer offered in the reset cycle SHALL be ignored.
REQ-028 in_ready SHALL be 0 while rst=1.

Structure
REQ-029 Shared package SHALL hold WIDTH and CNT_W defaults and the channel-index constants CH0=0, CH1=1.
REQ-030 Sub-module demux_slot (one-entry buffer with full flag, data register, wrapping counter) SHALL be instantiated twice; the top holds only select decode and in_ready logic.

Verification
REQ-031 Reset then idle: cnt0=cnt1=0, out0_valid=out1_valid=0, in_ready=1 after rst falls.
REQ-032 Send 8'hA5 sel=0 then 8'h3C sel=1 with both readys=1 -> out0_data=A5 one cycle after acceptance, out1_data=3C next cycle; cnt0=1, cnt1=1.
REQ-033 out0_ready=0, send 8'h11 sel=0 then 8'h22 sel=0 -> second word stalls (in_ready=0), out0_data stays 11; send 8'h33 sel=1 meanwhile -> accepted, out1_data=33.
REQ-034 Continuous stream sel=1, out1_ready=1 every cycle, 10 words -> in_ready held 1, one word per cycle on out1, cnt1=10.
REQ-035 CNT_W=8, deliver 257 words on channel 0 -> cnt0=1 (wrap verified).
REQ-036 Fill both slots, assert rst one cycle with in_valid=1 -> both valids 0, counters 0, offered word lost.
